// File: rtl/conv_pkg.sv
// conv_pkg: shared types for the convolution frame transmitter.
package conv_pkg;
    localparam int MAX_DIM = 1024;
    localparam int PIX_W   = 8;

    typedef logic [$clog2(MAX_DIM):0] dim_t;
    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        pixel_t data;
        logic   user;
        logic   last;
    } beat_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;
endpackage

// File: rtl/conv_skid.sv
// conv_skid: 2-entry skid buffer with registered outputs and full throughput.
module conv_skid #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic arst_n,
    input  logic in_vld_i,
    input  T     in_dat_i,
    output logic full_o,
    output logic empty_o,
    output logic out_vld_o,
    input  logic out_rdy_i,
    output T     out_dat_o
);
    logic [1:0] cnt_q, cnt_d;
    T           head_q, head_d, skid_q, skid_d;
    logic       pop, psh;

    assign pop       = out_vld_o && out_rdy_i;
    assign psh       = in_vld_i && (!full_o || pop);
    assign full_o    = cnt_q == 2'd2;
    assign empty_o   = cnt_q == 2'd0;
    assign out_vld_o = !empty_o;
    assign out_dat_o = head_q;

    // head refills from skid when it holds the older beat, otherwise from the input
    always_comb begin
        cnt_d  = cnt_q + {1'b0, psh} - {1'b0, pop};
        head_d = (pop || empty_o) ? (full_o ? skid_q : in_dat_i) : head_q;
        skid_d = (psh && cnt_d == 2'd2) ? in_dat_i : skid_q;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) cnt_q <= 2'd0;
        else         cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        skid_q <= skid_d;
    end
endmodule

// File: rtl/conv_frame_tx.sv
// conv_frame_tx: frames raw pixels into an AXI-stream with SOF (tuser) and EOL (tlast) tags.
module conv_frame_tx
    import conv_pkg::*;
(
    input  logic   clk,
    input  logic   arst_n,
    input  logic   start_i,
    input  dim_t   cfg_width_i,
    input  dim_t   cfg_height_i,
    output logic   busy_o,
    output logic   done_o,
    output logic   cfg_err_o,
    input  logic   pix_vld_i,
    input  pixel_t pix_dat_i,
    output logic   pix_rdy_o,
    output logic   m_tvalid_o,
    output pixel_t m_tdata_o,
    output logic   m_tuser_o,
    output logic   m_tlast_o,
    input  logic   m_tready_i
);
    state_e state_q, state_d;
    dim_t   col_q, col_d, row_q, row_d, w_q, w_d, h_q, h_d;
    logic   err_q, err_d;
    logic   full, empty, acc, eol, eof;
    beat_t  beat, m_beat;

    assign pix_rdy_o = state_q == ACTIVE && !full;
    assign acc       = pix_vld_i && pix_rdy_o;
    assign eol       = col_q == w_q - dim_t'(1);
    assign eof       = eol && row_q == h_q - dim_t'(1);
    assign beat      = '{pix_dat_i, row_q == '0 && col_q == '0, eol};
    assign busy_o    = state_q != IDLE;
    assign done_o    = state_q == DRAIN && empty;
    assign cfg_err_o = err_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        w_d     = w_q;
        h_d     = h_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                if (cfg_width_i != '0 && cfg_height_i != '0) begin
                    w_d     = cfg_width_i;
                    h_d     = cfg_height_i;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = ACTIVE;
                end else begin
                    err_d = 1'b1;
                end
            end
            ACTIVE: if (acc) begin
                col_d   = eol ? '0 : col_q + dim_t'(1);
                row_d   = eol ? row_q + dim_t'(1) : row_q;
                state_d = eof ? DRAIN : ACTIVE;
            end
            DRAIN:   state_d = empty ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        w_q <= w_d;
        h_q <= h_d;
    end

    conv_skid #(.T(beat_t)) u_skid (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_vld_i  (acc),
        .in_dat_i  (beat),
        .full_o    (full),
        .empty_o   (empty),
        .out_vld_o (m_tvalid_o),
        .out_rdy_i (m_tready_i),
        .out_dat_o (m_beat)
    );

    assign m_tdata_o = m_beat.data;
    assign m_tuser_o = m_beat.user;
    assign m_tlast_o = m_beat.last;
endmodule

// File: tb/tb_conv_frame_tx.sv
// tb_conv_frame_tx: randomized frame stimulus checked against a per-frame expected beat list.
module tb_conv_frame_tx;
    import conv_pkg::*;

    logic   clk, arst_n, start_i, busy_o, done_o, cfg_err_o;
    dim_t   cfg_width_i, cfg_height_i;
    logic   pix_vld_i, pix_rdy_o, m_tvalid_o, m_tuser_o, m_tlast_o, m_tready_i;
    pixel_t pix_dat_i, m_tdata_o;
    int     n_chk = 0, n_err = 0;

    conv_frame_tx dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .start_i      (start_i),
        .cfg_width_i  (cfg_width_i),
        .cfg_height_i (cfg_height_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .cfg_err_o    (cfg_err_o),
        .pix_vld_i    (pix_vld_i),
        .pix_dat_i    (pix_dat_i),
        .pix_rdy_o    (pix_rdy_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tdata_o    (m_tdata_o),
        .m_tuser_o    (m_tuser_o),
        .m_tlast_o    (m_tlast_o),
        .m_tready_i   (m_tready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic start_frame(input int w, input int h);
        @(negedge clk);
        start_i      = 1'b1;
        cfg_width_i  = dim_t'(w);
        cfg_height_i = dim_t'(h);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic bad_start(input int w, input int h);
        start_frame(w, h);
        #1;
        chk("cfg_err_pulse", cfg_err_o, 1);
        chk("cfg_err_busy", busy_o, 0);
        @(negedge clk);
        #1;
        chk("cfg_err_once", {cfg_err_o, busy_o}, 0);
    endtask

    // vm: 0 always valid, 1 random gaps; rm: 0 always ready, 1 toggle, 2 random
    task automatic run_frame(input int w, input int h, input int vm, input int rm,
                             input int abort_at, input bit poke);
        pixel_t     pix[$];
        int         n, ii, oi, first_in, first_out, last_out;
        bit         stall, done_seen, err_seen, aborted;
        logic [9:0] held, exp;
        n = w * h; ii = 0; oi = 0; first_in = -1; first_out = -1; last_out = -1;
        stall = 0; done_seen = 0; err_seen = 0; aborted = 0; held = '0;
        for (int k = 0; k < n; k++) pix.push_back(pixel_t'($urandom));
        start_frame(w, h);
        chk("busy_after_start", busy_o, 1);
        for (int cyc = 0; cyc < 2000 && !done_seen && !aborted; cyc++) begin
            if (cyc > 0) @(negedge clk);
            m_tready_i = rm == 0 ? 1'b1 : rm == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            pix_vld_i  = ii < n && (vm == 0 || $urandom_range(0, 3) != 0);
            pix_dat_i  = ii < n ? pix[ii] : pixel_t'($urandom);
            start_i    = poke && cyc == 3;
            if (poke) begin
                cfg_width_i  = dim_t'(2);
                cfg_height_i = dim_t'(2);
            end
            #1;
            err_seen |= cfg_err_o;
            if (stall) chk("hold_stalled", {m_tdata_o, m_tuser_o, m_tlast_o}, held);
            if (ii - oi == 2) chk("rdy_when_full", pix_rdy_o, 0);
            chk("done", done_o, oi == n);
            if (done_o) done_seen = 1;
            if (m_tvalid_o && m_tready_i) begin
                exp = {pix[oi], oi == 0, (oi % w) == w - 1};
                chk("beat", {m_tdata_o, m_tuser_o, m_tlast_o}, exp);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                oi++;
                if (oi == abort_at) aborted = 1;
            end
            stall = m_tvalid_o && !m_tready_i;
            held  = {m_tdata_o, m_tuser_o, m_tlast_o};
            if (pix_vld_i && pix_rdy_o) begin
                if (first_in < 0) first_in = cyc;
                ii++;
            end
        end
        @(negedge clk);
        start_i   = 1'b0;
        pix_vld_i = 1'b0;
        if (aborted) begin
            arst_n = 1'b0;
            #1;
            chk("abort_tvalid", m_tvalid_o, 0);
            chk("abort_outs", {pix_rdy_o, busy_o, done_o, cfg_err_o}, 0);
            @(negedge clk);
            arst_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                #1;
                chk("abort_quiet", {done_o, m_tvalid_o, busy_o}, 0);
            end
        end else begin
            if (!done_seen) chk("timeout", 0, 1);
            if (poke) chk("start_ignored_err", err_seen, 0);
            if (vm == 0 && rm == 0) begin
                chk("throughput", last_out - first_out, n - 1);
                chk("latency", first_out - first_in, 1);
            end
            #1;
            chk("idle_after", {busy_o, done_o, m_tvalid_o}, 0);
        end
    endtask

    initial begin
        arst_n = 1'b0; start_i = 1'b0; cfg_width_i = '0; cfg_height_i = '0;
        pix_vld_i = 1'b0; pix_dat_i = '0; m_tready_i = 1'b0;
        #1;
        chk("reset_outs", {m_tvalid_o, pix_rdy_o, busy_o, done_o, cfg_err_o}, 0);
        #20;
        @(negedge clk);
        arst_n = 1'b1;
        run_frame(4, 3, 0, 0, 0, 0);
        run_frame(4, 3, 1, 1, 0, 0);
        run_frame(1, 1, 0, 0, 0, 0);
        run_frame(1, 5, 1, 2, 0, 0);
        bad_start(0, 3);
        bad_start(3, 0);
        run_frame(4, 3, 1, 2, 0, 1);
        run_frame(4, 3, 0, 0, 5, 0);
        run_frame(2, 2, 0, 0, 0, 0);
        for (int t = 0; t < 10; t++)
            run_frame($urandom_range(1, 6), $urandom_range(1, 4),
                      $urandom_range(0, 1), $urandom_range(0, 2), 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/conv_frame_tx.md
CONV_FRAME_TX -- requirements
Module: conv_frame_tx

Interface
REQ-001 Parameter: none; all dimensions come from conv_pkg types.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 arst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 start_i  in  1  one-cycle request to begin a frame.
REQ-005 cfg_width_i  in  conv_pkg::dim_t  pixels per line; sampled on accepted start.
REQ-006 cfg_height_i  in  conv_pkg::dim_t  lines per frame; sampled on accepted start.
REQ-007 busy_o  out  1  high when state is not IDLE.
REQ-008 done_o  out  1  one-cycle pulse on frame completion.
REQ-009 cfg_err_o  out  1  one-cycle pulse on rejected start.
REQ-010 pix_vld_i / pix_dat_i / pix_rdy_o  in/in/out  1/conv_pkg::pixel_t/1  upstream raw pixel handshake.
REQ-011 m_tvalid_o / m_tdata_o / m_tuser_o / m_tlast_o  out  1/conv_pkg::pixel_t/1/1  AXI-stream pixel output; tuser = start of frame, tlast = end of line.
REQ-012 m_tready_i  in  1  downstream ready.

Function
REQ-013 FSM states IDLE, ACTIVE, DRAIN; reset state IDLE.
REQ-014 IDLE: start_i with width!=0 and height!=0 latches cfg, clears col/row, moves to ACTIVE next cycle.
REQ-015 IDLE: start_i with width==0 or height==0 pulses cfg_err_o next cycle, state stays IDLE.
REQ-016 start_i outside IDLE is ignored; no cfg change, no cfg_err_o.
REQ-017 pix_rdy_o = (state==ACTIVE) and output buffer not full; pix_rdy_o is a pure function of registered state.
REQ-018 Upstream beat accepted when pix_vld_i && pix_rdy_o; it is tagged tuser=(row==0&&col==0) and tlast=(col==width-1).
REQ-019 On accept: col increments; at col==width-1, col wraps to 0 and row increments.
REQ-020 Accepting beat with row==height-1 && col==width-1 moves the FSM to DRAIN; there is no further upstream accept.
REQ-021 DRAIN: when the output buffer is empty, done_o pulses for one cycle and the FSM returns to IDLE in the same cycle.
REQ-022 Output path is a 2-entry skid buffer with registered outputs and full throughput (one beat/cycle when m_tready_i held high).
REQ-023 Latency: a beat accepted in cycle N with the buffer empty appears on m_t* in cycle N+1.
REQ-024 While m_tvalid_o && !m_tready_i, m_tdata_o/m_tuser_o/m_tlast_o hold stable.
REQ-025 Beat order is preserved; no beat is dropped or duplicated under any combination of bubbles and backpressure.
REQ-026 width==1: every beat carries tlast; height==1: frame ends after first line.
REQ-027 Simultaneous buffer push and pop with the buffer full is legal; occupancy is unchanged.

Reset
REQ-028 Asserting arst_n low forces IDLE, col=row=0, buffer empty, m_tvalid_o=0, pix_rdy_o=0, busy_o=0, done_o=0, cfg_err_o=0.
REQ-029 Reset mid-frame discards all buffered beats; no done_o is produced for the aborted frame.
REQ-030 Data registers (m_tdata_o, latched cfg) need no reset value.

Structure
REQ-031 conv_pkg holds dim_t (width = clog2 of max image dimension + 1) and the FSM state enum; pixel_t reused from conv_pkg.
REQ-032 The skid buffer is sub-module conv_skid, parameterised by payload type {pixel_t, tuser, tlast}.
REQ-033 Counters and FSM live in conv_frame_tx; the target is 120-400 lines of RTL in total.

Verification
REQ-034 Frame 4x3, pix_vld_i and m_tready_i always 1 -> 12 consecutive beats, tuser on beat 0 only, tlast on beats 3,7,11, done_o 1 cycle after beat 11 handshake.
REQ-035 Frame 4x3, m_tready_i toggling 1/0 each cycle and random pix_vld_i gaps -> same 12-beat sequence and tags, payload stable while stalled, pix_rdy_o=0 whenever buffer full.
REQ-036 Frame 1x1 -> single beat with tuser=1, tlast=1, then done_o; frame 1x5 -> 5 beats all tlast=1.
REQ-037 start_i with width=0 height=3 -> cfg_err_o pulse, busy_o stays 0; start_i during ACTIVE with new cfg -> ignored, current frame completes with original dims.
REQ-038 Reset asserted after beat 5 of 4x3 frame -> m_tvalid_o=0 immediately, no done_o; new 2x2 start afterwards -> 4 correctly tagged beats.
